// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS32 instruction-fetch front end.
// Holds the PC, drives the external PC+4 adder, and issues instruction-memory
// reads over a ready handshake. Delivers the IF/ID payload. Handles stalls
// through a one-entry skid buffer, and branch/jump redirects that keep the
// delay slot. Exception flushes wait for an outstanding read to drain.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] Add_A,
    output logic [31:0] Add_B,
    input  logic [31:0] Add_C,
    input  logic        IF_Stall,
    input  logic        ID_Branch,
    input  logic [31:0] ID_BranchTarget,
    input  logic        ID_Jump,
    input  logic [31:0] ID_JumpTarget,
    input  logic        EX_Exception,
    output logic [31:0] IMem_Address,
    output logic        IMem_Read,
    input  logic        IMem_Ready,
    input  logic [31:0] IMem_Data,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCAdd4,
    output logic        IF_Valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] skid_instr, skid_instr_next;
    logic [31:0] skid_pc, skid_pc_next;
    logic [31:0] skid_pc4, skid_pc4_next;
    logic [31:0] pending_target, pending_target_next;
    logic        pending_valid, pending_valid_next;
    logic [31:0] out_instr, out_instr_next;
    logic [31:0] out_pc, out_pc_next;
    logic [31:0] out_pc4, out_pc4_next;
    logic        out_valid, out_valid_next;

    logic        redirect_take;
    logic [31:0] redirect_target;

    // The PC feeds the shared adder and the memory; the request drops in HOLD and in reset.
    always_comb begin
        Add_A          = pc;
        Add_B          = 32'd4;
        IMem_Address   = pc;
        IMem_Read      = reset && (state != HOLD);
        IF_Instruction = out_instr;
        IF_PC          = out_pc;
        IF_PCAdd4      = out_pc4;
        IF_Valid       = out_valid;
    end

    // Redirects are only honoured when ID is moving and no drain is in progress; jump beats branch.
    always_comb begin
        redirect_target = ID_Jump ? ID_JumpTarget : ID_BranchTarget;
        redirect_take   = (ID_Branch || ID_Jump) && !IF_Stall && (state != DRAIN);
    end

    // Next-state and datapath updates; every register holds unless a case below changes it.
    always_comb begin
        state_next          = state;
        pc_next             = pc;
        skid_instr_next     = skid_instr;
        skid_pc_next        = skid_pc;
        skid_pc4_next       = skid_pc4;
        pending_target_next = pending_target;
        pending_valid_next  = pending_valid;
        out_instr_next      = out_instr;
        out_pc_next         = out_pc;
        out_pc4_next        = out_pc4;
        out_valid_next      = out_valid;

        case (state)
            FETCH: begin
                if (EX_Exception) begin
                    pending_valid_next = 1'b0;
                    skid_instr_next    = 32'd0;
                    skid_pc_next       = 32'd0;
                    skid_pc4_next      = 32'd0;
                    out_valid_next     = 1'b0;
                    if (IMem_Ready) begin
                        pc_next = EXC_VECTOR;
                    end else begin
                        // The read cannot be cancelled, so remember where to go once it returns.
                        pending_target_next = EXC_VECTOR;
                        pending_valid_next  = 1'b1;
                        state_next          = DRAIN;
                    end
                end else if (IMem_Ready) begin
                    if (pending_valid) begin
                        pc_next = pending_target;
                    end else if (redirect_take) begin
                        pc_next = redirect_target;
                    end else begin
                        pc_next = Add_C;
                    end
                    pending_valid_next = 1'b0;
                    if (!IF_Stall) begin
                        out_instr_next = IMem_Data;
                        out_pc_next    = pc;
                        out_pc4_next   = Add_C;
                        out_valid_next = 1'b1;
                    end else begin
                        skid_instr_next = IMem_Data;
                        skid_pc_next    = pc;
                        skid_pc4_next   = Add_C;
                        state_next      = HOLD;
                    end
                end else begin
                    if (!IF_Stall) begin
                        out_valid_next = 1'b0;
                    end
                    // The read in flight is the delay slot; the target waits until it completes.
                    if (redirect_take) begin
                        pending_target_next = redirect_target;
                        pending_valid_next  = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (EX_Exception) begin
                    pending_valid_next = 1'b0;
                    skid_instr_next    = 32'd0;
                    skid_pc_next       = 32'd0;
                    skid_pc4_next      = 32'd0;
                    out_valid_next     = 1'b0;
                    pc_next            = EXC_VECTOR;
                    state_next         = FETCH;
                end else if (!IF_Stall) begin
                    out_instr_next = skid_instr;
                    out_pc_next    = skid_pc;
                    out_pc4_next   = skid_pc4;
                    out_valid_next = 1'b1;
                    state_next     = FETCH;
                    if (redirect_take) begin
                        pc_next = redirect_target;
                    end
                end
            end

            DRAIN: begin
                out_valid_next = 1'b0;
                if (IMem_Ready) begin
                    pc_next            = EX_Exception ? EXC_VECTOR : pending_target;
                    pending_valid_next = 1'b0;
                    state_next         = FETCH;
                end else if (EX_Exception) begin
                    pending_target_next = EXC_VECTOR;
                    pending_valid_next  = 1'b1;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State, PC, skid, pending and IF/ID registers, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= FETCH;
            pc             <= RESET_VECTOR;
            skid_instr     <= 32'd0;
            skid_pc        <= 32'd0;
            skid_pc4       <= 32'd0;
            pending_target <= 32'd0;
            pending_valid  <= 1'b0;
            out_instr      <= 32'd0;
            out_pc         <= 32'd0;
            out_pc4        <= 32'd0;
            out_valid      <= 1'b0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            skid_instr     <= skid_instr_next;
            skid_pc        <= skid_pc_next;
            skid_pc4       <= skid_pc4_next;
            pending_target <= pending_target_next;
            pending_valid  <= pending_valid_next;
            out_instr      <= out_instr_next;
            out_pc         <= out_pc_next;
            out_pc4        <= out_pc4_next;
            out_valid      <= out_valid_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit with a delivery scoreboard.
// The bench supplies the PC+4 adder and an instruction memory whose word is a
// fixed function of the address, so every delivered payload is predictable.
module tb_pc_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] add_a, add_b, add_c;
    logic        if_stall;
    logic        id_branch, id_jump, ex_exception;
    logic [31:0] id_branch_target, id_jump_target;
    logic [31:0] imem_address, imem_data;
    logic        imem_read, imem_ready;
    logic [31:0] if_instruction, if_pc, if_pcadd4;
    logic        if_valid;

    exp_t sb_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    pc_fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .Add_A           (add_a),
        .Add_B           (add_b),
        .Add_C           (add_c),
        .IF_Stall        (if_stall),
        .ID_Branch       (id_branch),
        .ID_BranchTarget (id_branch_target),
        .ID_Jump         (id_jump),
        .ID_JumpTarget   (id_jump_target),
        .EX_Exception    (ex_exception),
        .IMem_Address    (imem_address),
        .IMem_Read       (imem_read),
        .IMem_Ready      (imem_ready),
        .IMem_Data       (imem_data),
        .IF_Instruction  (if_instruction),
        .IF_PC           (if_pc),
        .IF_PCAdd4       (if_pcadd4),
        .IF_Valid        (if_valid)
    );

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return ~addr ^ 32'h1357_9BDF;
    endfunction

    // External adder and memory
    assign add_c     = add_a + add_b;
    assign imem_data = word_at(imem_address);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic ready, input logic stall,
                                 input logic branch, input logic [31:0] btarget,
                                 input logic jump, input logic [31:0] jtarget,
                                 input logic exc);
        imem_ready       = ready;
        if_stall         = stall;
        id_branch        = branch;
        id_branch_target = btarget;
        id_jump          = jump;
        id_jump_target   = jtarget;
        ex_exception     = exc;
    endtask

    task automatic push_exp(input logic [31:0] addr);
        exp_t e;
        e.instr = word_at(addr);
        e.pc    = addr;
        e.pc4   = addr + 32'd4;
        sb_q.push_back(e);
    endtask

    // One clock: request checked before the edge, payload and scoreboard after it.
    task automatic cycle(input logic [31:0] exp_addr, input logic exp_read, input logic exp_valid);
        logic stall_edge;
        exp_t e;
        @(negedge clock);
        checkOutput("imem_address", imem_address, exp_addr);
        checkOutput("imem_read", {31'd0, imem_read}, {31'd0, exp_read});
        @(posedge clock);
        stall_edge = if_stall;
        #1;
        checkOutput("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
        if (!stall_edge && if_valid) begin
            checkOutput("sb_has_entry", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput("if_instruction", if_instruction, e.instr);
                checkOutput("if_pc", if_pc, e.pc);
                checkOutput("if_pcadd4", if_pcadd4, e.pc4);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        // Reset state
        checkOutput("rst_imem_read", {31'd0, imem_read}, 32'd0);
        checkOutput("rst_address", imem_address, 32'hBFC0_0000);
        checkOutput("rst_add_b", add_b, 32'd4);
        checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'd0);
        checkOutput("rst_if_instruction", if_instruction, 32'd0);
        checkOutput("rst_if_pcadd4", if_pcadd4, 32'd0);
        reset = 1'b1;

        // Sequential fetch from the reset vector
        push_exp(32'hBFC0_0000); cycle(32'hBFC0_0000, 1'b1, 1'b1);
        push_exp(32'hBFC0_0004); cycle(32'hBFC0_0004, 1'b1, 1'b1);
        push_exp(32'hBFC0_0008); cycle(32'hBFC0_0008, 1'b1, 1'b1);

        // Jump to 0x100 on a completing fetch; BFC0000C is the delay slot
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100, 1'b0);
        push_exp(32'hBFC0_000C); cycle(32'hBFC0_000C, 1'b1, 1'b1);

        // Three wait cycles at 0x100, then delivery
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(32'h100, 1'b1, 1'b0);
        cycle(32'h100, 1'b1, 1'b0);
        cycle(32'h100, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        push_exp(32'h100); cycle(32'h100, 1'b1, 1'b1);

        // Branch to 0x400 while 0x104 is still outstanding
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'd0, 1'b0);
        cycle(32'h104, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(32'h104, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        push_exp(32'h104); cycle(32'h104, 1'b1, 1'b1);
        push_exp(32'h400); cycle(32'h400, 1'b1, 1'b1);

        // Branch and jump together: jump target wins
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h600, 1'b1, 32'h800, 1'b0);
        cycle(32'h404, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        push_exp(32'h404); cycle(32'h404, 1'b1, 1'b1);
        push_exp(32'h800); cycle(32'h800, 1'b1, 1'b1);

        // Jump to 0x200, then stall on its completion
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h200, 1'b0);
        push_exp(32'h804); cycle(32'h804, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(32'h200, 1'b1, 1'b1);
        checkOutput("stall_frozen_pc", if_pc, 32'h804);
        cycle(32'h204, 1'b0, 1'b1);
        checkOutput("hold_frozen_pc", if_pc, 32'h804);
        checkOutput("hold_frozen_instr", if_instruction, word_at(32'h804));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        push_exp(32'h200); cycle(32'h204, 1'b0, 1'b1);
        push_exp(32'h204); cycle(32'h204, 1'b1, 1'b1);

        // Jump to 0x300, exception while its fetch is outstanding
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h300, 1'b0);
        push_exp(32'h208); cycle(32'h208, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        cycle(32'h300, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(32'h300, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(32'h300, 1'b1, 1'b0);
        checkOutput("drain_kept_pc", if_pc, 32'h208);
        push_exp(32'hBFC0_0380); cycle(32'hBFC0_0380, 1'b1, 1'b1);

        // Jump to the top of the address space and wrap to zero
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        push_exp(32'hBFC0_0384); cycle(32'hBFC0_0384, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        push_exp(32'hFFFF_FFFC); cycle(32'hFFFF_FFFC, 1'b1, 1'b1);
        push_exp(32'h0000_0000); cycle(32'h0000_0000, 1'b1, 1'b1);

        // Exception on a completing fetch: data dropped, vector next cycle
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        cycle(32'h0000_0004, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        push_exp(32'hBFC0_0380); cycle(32'hBFC0_0380, 1'b1, 1'b1);

        checkOutput("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
